regfile_mp_sb: RTL

//  Parametrised multi-port register file with write-to-read bypass, optional hardwired zero

---
 rtl/regfile_mp_sb_pkg.sv | 17 +
 rtl/regfile_mp_sb_scoreboard.sv | 50 +++++
 rtl/regfile_mp_sb.sv | 100 ++++++++++
 3 files changed

// File: rtl/regfile_mp_sb_pkg.sv
// Shared definitions for the decode-stage register file: default sizes,
// address-width helper and the address type.
package wisc_rf_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int NUM_REGS_DEF = 16;

    // Address width needed to select one of n registers.
    function automatic int calc_aw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int AW_DEF = calc_aw(NUM_REGS_DEF);

    typedef logic [AW_DEF-1:0] rf_addr_t;

endpackage

// File: rtl/regfile_mp_sb_scoreboard.sv
// Pending-producer scoreboard: one flag per register, set at issue,
// cleared by writeback, with issue taking priority over a same-cycle clear.
module regfile_scoreboard
    import wisc_rf_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = calc_aw(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    output logic [NUM_REGS-1:0]  pend_vec
);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;

    // Clears first, then the issue set, so a new producer overrides a retiring one.
    always_comb begin
        pend_d = pend_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w]) begin
                pend_d[wr_addr[w*AW +: AW]] = 1'b0;
            end
        end
        if (iss_en) begin
            pend_d[iss_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pend_d[0] = 1'b0;
        end
    end

    // Pending flags register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_vec = pend_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-to-read bypass, optional hardwired
// zero register and a pending scoreboard used by decode to stall.
module regfile_mp_sb
    import wisc_rf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = calc_aw(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_ready,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr,
    output logic [NUM_REGS-1:0]      pend_vec
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [AW-1:0]     wa     [NUM_WR];
    logic [DATA_W-1:0] wd     [NUM_WR];

    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
        assign wa[w] = wr_addr[w*AW +: AW];
        assign wd[w] = wr_data[w*DATA_W +: DATA_W];
    end

    // Apply writes in port order so the highest-numbered (youngest) port wins.
    always_comb begin
        regs_d = regs_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && !((ZERO_REG != 0) && (wa[w] == '0))) begin
                regs_d[wa[w]] = wd[w];
            end
        end
    end

    // Register storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .pend_vec (pend_vec)
    );

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]     ra;
        logic [DATA_W-1:0] rdat;
        logic              hit;
        logic              is_zero;

        assign ra      = rd_addr[p*AW +: AW];
        assign is_zero = (ZERO_REG != 0) && (ra == '0);

        // Bypass mux: stored value, overridden by the youngest matching write.
        always_comb begin
            rdat = regs_q[ra];
            hit  = 1'b0;
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && (wa[w] == ra)) begin
                    rdat = wd[w];
                    hit  = 1'b1;
                end
            end
            if (is_zero) begin
                rdat = '0;
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = rdat;
        // Old pending bit is used, so a same-cycle issue does not stall its own reads.
        assign rd_ready[p] = is_zero | ~pend_vec[ra] | hit;
    end

endmodule
